// File: rtl/ram_check.sv
// Read-back checker for the block-RAM pattern generator. It snoops the write/read bus, keeps a
// shadow copy of every written word, and compares the RAM read data against it RD_LAT clocks later.
module ram_check #(
    parameter int unsigned ADDR_W = 5,
    parameter int unsigned DATA_W = 8,
    parameter int unsigned RD_LAT = 1
) (
    input  logic              sys_clk,
    input  logic              sys_rst_n,
    input  logic              ram_en,
    input  logic              ram_we,
    input  logic [ADDR_W-1:0] ram_addr,
    input  logic [DATA_W-1:0] ram_wdata,
    input  logic [DATA_W-1:0] ram_rdata,
    output logic              chk_pass,
    output logic              err_flag,
    output logic [7:0]        err_cnt,
    output logic [ADDR_W-1:0] err_addr,
    output logic [15:0]       sweep_cnt,
    output logic              led
);

    localparam int unsigned DEPTH = 2 ** ADDR_W;
    localparam logic [ADDR_W-1:0] LAST_IDX = '1;

    typedef enum logic [1:0] {
        IDLE,
        WRITE,
        READ
    } state_t;

    typedef struct packed {
        logic              vld;
        logic [DATA_W-1:0] expected;
        logic [ADDR_W-1:0] addr;
        logic              chk;
        logic              first;
        logic              last;
    } rd_tag_t;

    state_t            state;
    logic [ADDR_W-1:0] sweep_idx;
    logic              sweep_err;
    logic [DEPTH-1:0]  valid;
    logic [DATA_W-1:0] shadow [DEPTH];
    rd_tag_t           pipe [RD_LAT];

    logic              wr;
    logic              rd;
    logic [ADDR_W-1:0] idx;
    rd_tag_t           head;
    rd_tag_t           tail;
    logic              mis;
    logic              sweep_bad;

    always_comb begin
        wr            = ram_en & ram_we;
        rd            = ram_en & ~ram_we;
        // A read arriving from IDLE or WRITE starts a new sweep at index 0.
        idx           = (state == READ) ? sweep_idx : '0;
        head.vld      = rd;
        head.expected = shadow[ram_addr];
        head.addr     = ram_addr;
        head.chk      = valid[ram_addr];
        head.first    = (idx == '0);
        head.last     = (idx == LAST_IDX);
        tail          = pipe[RD_LAT-1];
        mis           = tail.vld & tail.chk & (ram_rdata != tail.expected);
        // Sweep error is accumulated on the compare side so that mismatches still in flight when
        // the last read issues are not lost; the first word of a sweep discards the old history.
        sweep_bad     = (~tail.first & sweep_err) | mis;
    end

    // Shadow data has no reset: the valid bits alone decide whether a word is checked.
    always_ff @(posedge sys_clk) begin
        if (wr) begin
            shadow[ram_addr] <= ram_wdata;
        end
    end

    always_ff @(posedge sys_clk) begin
        if (!sys_rst_n) begin
            state     <= IDLE;
            sweep_idx <= '0;
            sweep_err <= 1'b0;
            valid     <= '0;
            for (int unsigned i = 0; i < RD_LAT; i++) begin
                pipe[i].vld <= 1'b0;
            end
            chk_pass  <= 1'b0;
            err_flag  <= 1'b0;
            err_cnt   <= '0;
            err_addr  <= '0;
            sweep_cnt <= '0;
            led       <= 1'b1;
        end else begin
            chk_pass <= 1'b0;

            if (wr) begin
                valid[ram_addr] <= 1'b1;
                state           <= WRITE;
            end else if (rd) begin
                state     <= READ;
                sweep_idx <= idx + ADDR_W'(1);
            end

            pipe[0] <= head;
            for (int unsigned i = 1; i < RD_LAT; i++) begin
                pipe[i] <= pipe[i-1];
            end

            if (tail.vld) begin
                if (mis) begin
                    err_flag <= 1'b1;
                    led      <= 1'b0;
                    err_addr <= tail.addr;
                    if (err_cnt != 8'hFF) begin
                        err_cnt <= err_cnt + 8'd1;
                    end
                end
                if (tail.last) begin
                    sweep_err <= 1'b0;
                    if (!sweep_bad) begin
                        chk_pass  <= 1'b1;
                        sweep_cnt <= sweep_cnt + 16'd1;
                    end
                end else begin
                    sweep_err <= sweep_bad;
                end
            end
        end
    end

endmodule

// File: tb/tb_ram_check.sv
// Bench for ram_check: two instances (RD_LAT 1 and 3) share one generator bus; a transaction-level
// reference model predicts every output cycle by cycle.
module tb_ram_check;

    logic       clk;
    logic       rst_n;
    logic       en;
    logic       we;
    logic [4:0] addr;
    logic [7:0] wdata;
    logic [7:0] xor_mask;
    logic       fill;

    logic [7:0] tbram [32];
    logic [7:0] rq1, rq2, rq3;

    logic       pass_o  [2];
    logic       flag_o  [2];
    logic       led_o   [2];
    logic [7:0] cnt_o   [2];
    logic [4:0] eaddr_o [2];
    logic [15:0] swp_o  [2];

    ram_check #(.ADDR_W(5), .DATA_W(8), .RD_LAT(1)) dut1 (
        .sys_clk(clk), .sys_rst_n(rst_n), .ram_en(en), .ram_we(we), .ram_addr(addr),
        .ram_wdata(wdata), .ram_rdata(rq1), .chk_pass(pass_o[0]), .err_flag(flag_o[0]),
        .err_cnt(cnt_o[0]), .err_addr(eaddr_o[0]), .sweep_cnt(swp_o[0]), .led(led_o[0])
    );

    ram_check #(.ADDR_W(5), .DATA_W(8), .RD_LAT(3)) dut3 (
        .sys_clk(clk), .sys_rst_n(rst_n), .ram_en(en), .ram_we(we), .ram_addr(addr),
        .ram_wdata(wdata), .ram_rdata(rq3), .chk_pass(pass_o[1]), .err_flag(flag_o[1]),
        .err_cnt(cnt_o[1]), .err_addr(eaddr_o[1]), .sweep_cnt(swp_o[1]), .led(led_o[1])
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Block-RAM model: registered read (latency 1), plus two extra stages for latency 3.
    always @(posedge clk) begin
        if (fill) begin
            for (int i = 0; i < 32; i++) tbram[i] <= 8'hFF;
        end else if (en && we) begin
            tbram[addr] <= wdata;
        end
        if (en && !we) rq1 <= tbram[addr] ^ xor_mask;
        rq2 <= rq1;
        rq3 <= rq2;
    end

    // ---------------- reference model ----------------
    typedef struct {
        int       due;
        int       lane;
        bit       mis;
        bit       pass;
        bit [4:0] a;
    } ev_t;

    ev_t        evq[$];
    bit         m_valid [32];
    bit [7:0]   m_shadow [32];
    bit         in_read;
    int         pos;
    bit         bad;
    bit         m_pass [2];
    bit         m_flag [2];
    int         m_cnt [2];
    bit [4:0]   m_eaddr [2];
    bit [15:0]  m_swp [2];
    int         lat [2] = '{1, 3};

    int cyc = 0;
    int n_cmp = 0;
    int n_bad = 0;
    int p_cyc [2];
    int n_pass [2];

    task automatic model_edge();
        ev_t keep[$];
        bit  mis;
        bit  last;
        bit [7:0] ret;
        if (!rst_n) begin
            evq.delete();
            in_read = 0;
            for (int i = 0; i < 32; i++) m_valid[i] = 0;
            for (int l = 0; l < 2; l++) begin
                m_pass[l] = 0; m_flag[l] = 0; m_cnt[l] = 0; m_eaddr[l] = 0; m_swp[l] = 0;
            end
            return;
        end
        for (int l = 0; l < 2; l++) m_pass[l] = 0;
        foreach (evq[i]) begin
            if (evq[i].due == cyc) begin
                if (evq[i].mis) begin
                    m_flag[evq[i].lane]  = 1;
                    m_eaddr[evq[i].lane] = evq[i].a;
                    if (m_cnt[evq[i].lane] < 255) m_cnt[evq[i].lane]++;
                end
                if (evq[i].pass) begin
                    m_pass[evq[i].lane] = 1;
                    m_swp[evq[i].lane]++;
                end
            end else begin
                keep.push_back(evq[i]);
            end
        end
        evq = keep;
        if (en && we) begin
            m_shadow[addr] = wdata;
            m_valid[addr]  = 1;
            in_read        = 0;
        end else if (en) begin
            if (!in_read) begin
                pos = 0;
                bad = 0;
            end
            ret  = tbram[addr] ^ xor_mask;
            mis  = m_valid[addr] && (ret != m_shadow[addr]);
            bad  = bad | mis;
            last = (pos == 31);
            for (int l = 0; l < 2; l++)
                evq.push_back('{due: cyc + lat[l], lane: l, mis: mis, pass: last && !bad, a: addr});
            pos++;
            if (last) begin
                pos = 0;
                bad = 0;
            end
            in_read = 1;
        end
    endtask

    // ---------------- checking ----------------
    task automatic cmp(input string tag, input logic [15:0] obs, input logic [15:0] exp_v);
        n_cmp++;
        assert (obs === exp_v)
        else begin
            n_bad++;
            $error("FAIL %s: got %0h expected %0h", tag, obs, exp_v);
        end
    endtask

    task automatic check();
        for (int l = 0; l < 2; l++) begin
            cmp($sformatf("chk_pass[L%0d] cyc%0d", lat[l], cyc), 16'(pass_o[l]), 16'(m_pass[l]));
            cmp($sformatf("err_flag[L%0d] cyc%0d", lat[l], cyc), 16'(flag_o[l]), 16'(m_flag[l]));
            cmp($sformatf("led[L%0d] cyc%0d", lat[l], cyc), 16'(led_o[l]), 16'(!m_flag[l]));
            cmp($sformatf("err_cnt[L%0d] cyc%0d", lat[l], cyc), 16'(cnt_o[l]), 16'(m_cnt[l]));
            cmp($sformatf("err_addr[L%0d] cyc%0d", lat[l], cyc), 16'(eaddr_o[l]), 16'(m_eaddr[l]));
            cmp($sformatf("sweep_cnt[L%0d] cyc%0d", lat[l], cyc), swp_o[l], m_swp[l]);
            if (pass_o[l] === 1'b1) begin
                p_cyc[l] = cyc;
                n_pass[l]++;
            end
        end
    endtask

    // ---------------- stimulus helpers ----------------
    task automatic step(input bit e, input bit w, input int a, input logic [7:0] d,
                        input logic [7:0] m);
        en = e; we = w; addr = a[4:0]; wdata = d; xor_mask = m;
        @(posedge clk);
        cyc++;
        model_edge();
        #1;
        check();
    endtask

    task automatic idle(input int n);
        repeat (n) step(0, 0, 0, 8'h00, 8'h00);
    endtask

    task automatic do_reset();
        rst_n = 0;
        idle(2);
        rst_n = 1;
        for (int l = 0; l < 2; l++) begin
            n_pass[l] = 0;
            p_cyc[l]  = -1;
        end
    endtask

    task automatic write_all();
        for (int a = 0; a < 32; a++) step(1, 1, a, 8'(a + 1), 8'h00);
    endtask

    task automatic read_all(input int bad_a, output int last_c);
        for (int a = 0; a < 32; a++) step(1, 0, a, 8'h00, (a == bad_a) ? 8'h01 : 8'h00);
        last_c = cyc;
    endtask

    int last_rd;

    initial begin
        rst_n = 0; en = 0; we = 0; addr = '0; wdata = '0; xor_mask = '0; fill = 0;
        do_reset();

        // T1 nominal sweep
        write_all();
        read_all(-1, last_rd);
        idle(5);
        cmp("t1_pass_cycle_L1", 16'(p_cyc[0]), 16'(last_rd + 1));
        cmp("t1_pass_count_L1", 16'(n_pass[0]), 16'd1);
        cmp("t1_sweep_cnt_L1", swp_o[0], 16'd1);
        cmp("t1_err_cnt_L1", 16'(cnt_o[0]), 16'd0);

        // T2 corruption at addr 5, then a clean sweep
        do_reset();
        write_all();
        read_all(5, last_rd);
        idle(5);
        cmp("t2_pass_count", 16'(n_pass[0]), 16'd0);
        cmp("t2_err_addr", 16'(eaddr_o[0]), 16'd5);
        cmp("t2_err_cnt", 16'(cnt_o[0]), 16'd1);
        cmp("t2_led", 16'(led_o[0]), 16'd0);
        read_all(-1, last_rd);
        idle(5);
        cmp("t2_clean_sweep_cnt", swp_o[0], 16'd1);
        cmp("t2_flag_sticky", 16'(flag_o[0]), 16'd1);

        // T3 reads of unwritten words
        do_reset();
        fill = 1;
        idle(1);
        fill = 0;
        read_all(-1, last_rd);
        idle(5);
        cmp("t3_pass_count", 16'(n_pass[0]), 16'd1);
        cmp("t3_err_cnt", 16'(cnt_o[0]), 16'd0);

        // T4 aborted sweep
        do_reset();
        write_all();
        for (int a = 0; a < 10; a++) step(1, 0, a, 8'h00, 8'h00);
        step(1, 1, 0, 8'h01, 8'h00);
        read_all(-1, last_rd);
        idle(5);
        cmp("t4_pass_count_L1", 16'(n_pass[0]), 16'd1);
        cmp("t4_pass_count_L3", 16'(n_pass[1]), 16'd1);
        cmp("t4_sweep_cnt", swp_o[1], 16'd1);

        // T5 saturation
        do_reset();
        write_all();
        for (int i = 0; i < 300; i++) step(1, 0, i % 32, 8'h00, 8'h01);
        idle(5);
        cmp("t5_err_cnt_L1", 16'(cnt_o[0]), 16'd255);
        cmp("t5_err_cnt_L3", 16'(cnt_o[1]), 16'd255);

        // T6 reset right after a mismatching read, then latency comparison
        do_reset();
        write_all();
        step(1, 0, 7, 8'h00, 8'h01);
        rst_n = 0;
        idle(2);
        rst_n = 1;
        idle(6);
        cmp("t6_flag_L3", 16'(flag_o[1]), 16'd0);
        cmp("t6_err_cnt_L3", 16'(cnt_o[1]), 16'd0);
        cmp("t6_led_L3", 16'(led_o[1]), 16'd1);
        do_reset();
        write_all();
        read_all(-1, last_rd);
        idle(5);
        cmp("t6_lat_delta", 16'(p_cyc[1] - p_cyc[0]), 16'd2);
        cmp("t6_pass_cycle_L3", 16'(p_cyc[1]), 16'(last_rd + 3));

        // Randomized sweeps with gaps, aborts and sporadic corruption
        do_reset();
        for (int a = 0; a < 32; a++) step(1, 1, a, 8'($urandom), 8'h00);
        for (int s = 0; s < 8; s++) begin
            for (int k = 0; k < 32; k++) begin
                if ($urandom_range(0, 3) == 0) idle($urandom_range(1, 3));
                if ($urandom_range(0, 60) == 0)
                    step(1, 1, $urandom_range(0, 31), 8'($urandom), 8'h00);
                step(1, 0, $urandom_range(0, 31), 8'h00,
                     ($urandom_range(0, 19) == 0) ? 8'(1 << $urandom_range(0, 7)) : 8'h00);
            end
        end
        idle(6);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
